// File: rtl/tff_count_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tff_count_ctrl                                                  |
// | Brief    : Sequencer that steps an external T flip-flop bank up or down    |
// |            to a target value, with optional clear-and-verify first.        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tff_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic             clr_first,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] t,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH:0]   steps
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_CLEAR  = 3'd1;
    localparam logic [2:0] c_ST_VERIFY = 3'd2;
    localparam logic [2:0] c_ST_RUN    = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;
    localparam logic [2:0] c_ST_FAIL   = 3'd5;

    localparam logic [WIDTH:0] c_STEP_LIMIT = (WIDTH+1)'(1) << WIDTH;
    localparam logic [WIDTH:0] c_STEP_MAX   = '1;

    logic [2:0]       r_state;
    logic             r_dir;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH:0]   r_steps;

    logic [2:0]       w_state_nxt;
    logic [WIDTH-1:0] w_t;
    logic             w_step_en;
    logic [WIDTH-1:0] w_up_chain;
    logic [WIDTH-1:0] w_dn_chain;

    // Prefix-AND chains: bit i toggles when every lower bit is 1 (up) or 0 (down).
    assign w_up_chain[0] = 1'b1;
    assign w_dn_chain[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_toggle
        assign w_up_chain[i] = w_up_chain[i-1] &  q[i-1];
        assign w_dn_chain[i] = w_dn_chain[i-1] & ~q[i-1];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_t         = '0;
        w_step_en   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // clr_first only steers this one transition, so it is used directly.
                if (start) w_state_nxt = clr_first ? c_ST_CLEAR : c_ST_RUN;
            end
            c_ST_CLEAR: begin
                w_t         = q;
                w_state_nxt = c_ST_VERIFY;
            end
            c_ST_VERIFY: begin
                w_state_nxt = (q == '0) ? c_ST_RUN : c_ST_FAIL;
            end
            c_ST_RUN: begin
                // Match wins over timeout so a bank landing on target at the limit still succeeds.
                if (q == r_target) begin
                    w_state_nxt = c_ST_DONE;
                end else if (r_steps == c_STEP_LIMIT) begin
                    w_state_nxt = c_ST_FAIL;
                end else begin
                    w_t       = r_dir ? w_up_chain : w_dn_chain;
                    w_step_en = 1'b1;
                end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            c_ST_FAIL: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_dir    <= 1'b0;
            r_target <= '0;
            r_steps  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_IDLE && start) begin
                r_dir    <= dir;
                r_target <= target;
                r_steps  <= '0;
            end else if (w_step_en && r_steps != c_STEP_MAX) begin
                r_steps <= r_steps + 1'b1;
            end
        end
    end

    assign t     = rst ? '0 : w_t;
    assign busy  = (r_state == c_ST_CLEAR) || (r_state == c_ST_RUN);
    assign done  = (r_state == c_ST_DONE);
    assign err   = (r_state == c_ST_FAIL);
    assign steps = r_steps;

endmodule
`default_nettype wire

// File: tb/tb_tff_count_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tff_count_ctrl                                               |
// | Brief    : Scoreboard bench driving tff_count_ctrl against a 4-bit TFF     |
// |            bank model with optional stuck bits.                            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_tff_count_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       dir = 1'b0;
    logic       clr_first = 1'b0;
    logic [3:0] target = 4'd0;
    logic [3:0] q;
    logic [3:0] t;
    logic       busy;
    logic       done;
    logic       err;
    logic [4:0] steps;

    logic [3:0] r_bank = 4'd0;
    logic [3:0] and_mask = 4'hF;
    logic [3:0] or_mask = 4'h0;
    logic [3:0] load_val = 4'd0;
    logic       load_en = 1'b0;
    int         cyc = 0;

    // Observed Q: stuck-at-0 bits cleared by and_mask, stuck-at-1 bits set by or_mask.
    assign q = (r_bank & and_mask) | or_mask;

    tff_count_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .clr_first(clr_first),
        .target(target), .q(q), .t(t), .busy(busy), .done(done), .err(err),
        .steps(steps)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        r_bank <= load_en ? load_val : (r_bank ^ t);
        cyc    <= cyc + 1;
    end

    typedef struct {
        int is_err;
        int steps;
        int q;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_steps = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Walks the bank value one unit at a time until it meets the target or the 16-step limit.
    function automatic exp_t model(input logic [3:0] init, input bit d, input bit clr,
                                   input logic [3:0] tgt, input logic [3:0] am,
                                   input logic [3:0] om, input int issue_cyc);
        exp_t e;
        int   cur = (int'(init) & int'(am)) | int'(om);
        int   s = 0;
        int   lat = 1;
        if (clr) begin
            cur = int'(om);
            lat = 3;
            if (cur != 0) begin
                e.is_err = 1; e.steps = 0; e.q = cur; e.cyc = issue_cyc + 1 + 2;
                return e;
            end
        end
        while (cur != int'(tgt) && s < 16) begin
            cur = ((d ? cur + 1 : cur + 15) % 16);
            cur = (cur & int'(am)) | int'(om);
            s++;
        end
        e.is_err = (cur != int'(tgt)) ? 1 : 0;
        e.steps  = s;
        e.q      = cur;
        e.cyc    = issue_cyc + 1 + lat + s;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            chk("done_err_exclusive", int'(done & err), 0);
            if (!busy) chk("t_zero_when_not_busy", int'(t), 0);
            if (done || err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_end_pulse", int'(done) + 2 * int'(err), 0);
                end else begin
                    e = sb.pop_front();
                    chk("end_is_err", int'(err), e.is_err);
                    chk("end_is_done", int'(done), 1 - e.is_err);
                    chk("steps_at_end", int'(steps), e.steps);
                    chk("q_at_end", int'(q), e.q);
                    chk("latency", cyc, e.cyc);
                    last_steps = e.steps;
                end
            end
        end
    end

    task automatic issue(input logic [3:0] init, input bit d, input bit clr,
                         input logic [3:0] tgt, input logic [3:0] am,
                         input logic [3:0] om, input bit expect_end);
        and_mask = am;
        or_mask  = om;
        load_val = init;
        load_en  = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        if (expect_end) sb.push_back(model(init, d, clr, tgt, am, om, cyc));
        start = 1'b1; dir = d; clr_first = clr; target = tgt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("completion_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 50000", cyc);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1);
    end

    initial begin : stim
        logic [3:0] am;
        logic [3:0] om;
        int         b;
        int         r;

        load_val = 4'd5;
        load_en  = 1'b1;
        repeat (2) @(negedge clk);
        load_en = 1'b0;
        repeat (2) begin
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_err", int'(err), 0);
            chk("rst_steps", int'(steps), 0);
            chk("rst_t", int'(t), 0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);

        issue(4'd5, 1'b1, 1'b0, 4'd9, 4'hF, 4'h0, 1'b1);   wait_idle();
        repeat (5) @(negedge clk);
        chk("steps_hold_idle", int'(steps), last_steps);
        issue(4'd11, 1'b1, 1'b1, 4'd2, 4'hF, 4'h0, 1'b1);  wait_idle();
        issue(4'd1, 1'b0, 1'b0, 4'd14, 4'hF, 4'h0, 1'b1);  wait_idle();
        issue(4'd15, 1'b1, 1'b0, 4'd0, 4'hF, 4'h0, 1'b1);  wait_idle();
        issue(4'd0, 1'b1, 1'b0, 4'd8, 4'h7, 4'h0, 1'b1);   wait_idle();
        chk("t_after_timeout", int'(t), 0);
        issue(4'd7, 1'b1, 1'b0, 4'd7, 4'hF, 4'h0, 1'b1);   wait_idle();
        issue(4'd6, 1'b1, 1'b1, 4'd3, 4'hF, 4'h4, 1'b1);   wait_idle();

        // A second start while running must not disturb the active sequence.
        issue(4'd0, 1'b1, 1'b0, 4'd12, 4'hF, 4'h0, 1'b1);
        repeat (3) @(negedge clk);
        start = 1'b1; dir = 1'b0; clr_first = 1'b1; target = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);

        issue(4'd0, 1'b1, 1'b0, 4'd10, 4'hF, 4'h0, 1'b0);
        repeat (2) @(negedge clk);
        chk("steps_before_reset", int'(steps), 2);
        rst = 1'b1;
        #1;
        chk("t_during_reset", int'(t), 0);
        @(negedge clk);
        chk("busy_after_reset", int'(busy), 0);
        chk("steps_after_reset", int'(steps), 0);
        chk("t_after_reset", int'(t), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            am = 4'hF;
            om = 4'h0;
            r  = int'($urandom_range(0, 9));
            b  = int'($urandom_range(0, 3));
            if (r == 0) am = ~(4'b0001 << b);
            if (r == 1) om = 4'b0001 << b;
            issue(4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), am, om, 1'b1);
            wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
